risc_alu_seq: RTL

- Parametrised, registered successor to the RiSC datapath ALU.
- Accepts one operation per valid/ready handshake, computes ADD/NAND/PASS1/SUB in one cycle, and holds the result in an output register until consumed.
- Adds carry/borrow, zero and illegal-opcode flags, plus an optional iterative shift-add multiplier.
- Sits between the register-file read stage and the writeback/branch-resolve stage of the pipelined RiSC core.

---
 rtl/risc_alu_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/risc_alu_seq.sv
// Registered RiSC ALU with valid/ready handshake: ADD/NAND/PASS1/SUB in one cycle, result held until consumed.
// Define RISC_ALU_MUL_EN to add the iterative shift-add multiplier on opcode 4.
module risc_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_eq,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1
`ifdef RISC_ALU_MUL_EN
        , S_MUL = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             eq_q, eq_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic             accept;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] op_result;
    logic             op_carry;
    logic             op_err;

`ifdef RISC_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    assign out_valid  = (state_q == S_HOLD);
    assign in_ready   = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_result = result_q;
    assign out_eq     = eq_q;
    assign out_zero   = zero_q;
    assign out_carry  = carry_q;
    assign out_err    = err_q;

    // Single-cycle operation results; opcode 4 lands in default (illegal) unless the multiplier path claims it.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        op_result = '0;
        op_carry  = 1'b0;
        op_err    = 1'b0;
        sum_ext   = {1'b0, in_src1} + {1'b0, in_src2};
        case (in_op)
            3'd0: begin
                op_result = sum_ext[WIDTH-1:0];
                op_carry  = sum_ext[WIDTH];
            end
            3'd1: op_result = ~(in_src1 & in_src2);
            3'd2: op_result = in_src1;
            3'd3: begin
                op_result = in_src1 + ~in_src2 + WIDTH'(1);
                op_carry  = (in_src1 < in_src2);
            end
            default: op_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        eq_d     = eq_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        err_d    = err_q;
`ifdef RISC_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    eq_d = (in_src1 == in_src2);
`ifdef RISC_ALU_MUL_EN
                    if (in_op == 3'd4) begin
                        mcand_d  = in_src1;
                        mplier_d = in_src2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else
`endif
                    begin
                        result_d = op_result;
                        carry_d  = op_carry;
                        zero_d   = (op_result == '0);
                        err_d    = op_err;
                        state_d  = S_HOLD;
                    end
                end else if ((state_q == S_HOLD) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef RISC_ALU_MUL_EN
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == '0);
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_HOLD;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            eq_q     <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef RISC_ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            eq_q     <= eq_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
`ifdef RISC_ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule
